kf6845_horizontal_control: RTL and testbench
============================================

// Module: kf6845_horizontal_control
// PURPOSE
// - Horizontal timing stage of the KF6845 CRTC; sits directly downstream of the bus control logic.
// - Owns R0-R3 (horizontal total, horizontal displayed, sync position, sync width); loads them from internal_data_bus on the write strobes.
// - Runs the character counter and generates horizontal display enable, HSYNC and an end-of-line pulse; the vertical stage consumes the pulse.
// PARAMETERS
// - none (all widths fixed by the 6845 register map)
// PORTS
// clock                                    in   1  system clock; single clock domain
// reset                                    in   1  synchronous, active-high
// character_clock_enable                   in   1  one-clock pulse per character time
// internal_data_bus                        in   8  register write data
// write_horizontal_total_register          in   1  load R0
// write_horizontal_displayed_register      in   1  load R1
// write_horizontal_sync_position_register  in   1  load R2
// write_horizontal_sync_width_register     in   1  load R3
// horizontal_count                         out  8  current character column
// horizontal_display                       out  1  column is inside displayed area
// HSYNC                                    out  1  horizontal sync, active-high
// end_of_line                              out  1  one-clock pulse after line wrap
// vertical_sync_width                      out  4  R3[7:4], passed to vertical stage
// BEHAVIOUR
// - Reset values: every register and output is 0 (HSYNC low, count 0, R0-R3 0, sync down-counter 0).
// - Register loads: on any clock edge where a write strobe is high, the register takes internal_data_bus.
//   - R0, R1 and R2 are 8 bits. R3[3:0] is the hsync width; R3[7:4] drives vertical_sync_width.
//   - A load and a char enable on the same edge: that edge's compares use the old value.
// - Counter: updates only on clock edges with character_clock_enable=1.
//   - next = (count==R0) ? 0 : count+1, with 8-bit wrap.
//   - If R0 is rewritten below the current count, the counter runs on to 255, wraps to 0 and resumes normally.
//   - R0=0: count stays 0 and every char enable produces an end_of_line.
// - end_of_line: registered. end_of_line <= character_clock_enable & (count==R0).
//   - High for exactly one clock, on the clock after the wrap edge.
// - horizontal_display: registered on char-enable edges as (next < R1).
//   - It therefore always matches horizontal_count; R1=0 means never displayed.
// - HSYNC: two-state FSM, IDLE and SYNC, plus a 5-bit down-counter.
//   - IDLE->SYNC on a char-enable edge where next==R2 and width!=0. HSYNC<=1 and the counter loads the width.
//   - In SYNC, on a char enable: counter-1. On the edge where the counter is 1: HSYNC<=0, go to IDLE.
//   - Net effect: HSYNC is high for exactly width characters.
//   - A sync-position match while in SYNC is ignored; there is no retrigger.
//   - HSYNC may span the line wrap.
//   - R2 > R0 means HSYNC never asserts.
//   - An R3 write during SYNC does not alter the sync in progress.
// - Reset mid-line or mid-sync: synchronous return to the reset values on the next edge. The first line restarts at column 0.
// - Without character_clock_enable, all state holds; register loads still happen.
// CONFIGURATION
// - KF6845_HSYNC_WIDTH_ZERO_IS_16_EN
//   - Defined: hsync width 0 means 16 characters (counter loads 16).
//   - Undefined: width 0 suppresses HSYNC entirely.
// TESTING
// - R0=9, R1=6, R2=7, R3=0x32, enable every clock -> count 0..9 repeating.
//   - horizontal_display high for columns 0-5.
//   - HSYNC high for columns 7,8.
//   - end_of_line pulses once per 10 enables; vertical_sync_width=3.
// - R0=3, R2=2, R3=0x05 -> HSYNC spans the wrap: high for columns 2,3,0,1,2 (5 characters), then low.
// - R3=0x00 -> macro undefined: HSYNC never high; macro defined: HSYNC high for 16 consecutive characters.
// - Enable every 3rd clock -> count and HSYNC change only on enable edges; end_of_line is still exactly one clock wide.
// - Count=200, then write R0=50 -> count runs to 255, wraps to 0, then wraps at 50.
// - Assert reset while HSYNC=1 and count=5 -> next edge: all outputs 0, FSM IDLE, R0-R3 cleared.

Source files
------------

// File: rtl/kf6845_horizontal_control_if.sv
// KF6845 horizontal control bus interface.
// Carries the character clock enable, the internal data bus and the four
// horizontal register write strobes from the bus control logic into the
// horizontal timing stage.
interface kf6845_horizontal_control_if;
    logic       character_clock_enable;
    logic [7:0] internal_data_bus;
    logic       write_horizontal_total_register;
    logic       write_horizontal_displayed_register;
    logic       write_horizontal_sync_position_register;
    logic       write_horizontal_sync_width_register;

    modport master (
        output character_clock_enable,
        output internal_data_bus,
        output write_horizontal_total_register,
        output write_horizontal_displayed_register,
        output write_horizontal_sync_position_register,
        output write_horizontal_sync_width_register
    );

    modport slave (
        input character_clock_enable,
        input internal_data_bus,
        input write_horizontal_total_register,
        input write_horizontal_displayed_register,
        input write_horizontal_sync_position_register,
        input write_horizontal_sync_width_register
    );
endinterface

// File: rtl/kf6845_horizontal_control.sv
// KF6845 CRTC horizontal timing stage.
// Holds R0-R3 (horizontal total, displayed, sync position, sync width), runs
// the character column counter and produces horizontal display enable, HSYNC
// and a one-clock end-of-line pulse for the vertical stage.
// Configuration macro: KF6845_HSYNC_WIDTH_ZERO_IS_16_EN
//   defined   -> an hsync width of 0 produces a 16-character sync
//   undefined -> an hsync width of 0 suppresses HSYNC
module kf6845_horizontal_control (
    input  logic                              clock,
    input  logic                              reset,
    kf6845_horizontal_control_if.slave        bus,
    output logic [7:0]                        horizontal_count,
    output logic                              horizontal_display,
    output logic                              HSYNC,
    output logic                              end_of_line,
    output logic [3:0]                        vertical_sync_width
);

    typedef enum logic [0:0] {
        HSYNC_IDLE = 1'b0,
        HSYNC_SYNC = 1'b1
    } hsync_state_t;

    logic [7:0]   r0_q, r0_d;
    logic [7:0]   r1_q, r1_d;
    logic [7:0]   r2_q, r2_d;
    logic [7:0]   r3_q, r3_d;

    logic [7:0]   count_q, count_d;
    logic         display_q, display_d;
    logic         eol_q, eol_d;

    hsync_state_t state_q, state_d;
    logic         hsync_q, hsync_d;
    logic [4:0]   sync_cnt_q, sync_cnt_d;

    logic         char_en;
    logic         line_end;
    logic [7:0]   count_next;
    logic [4:0]   sync_load;
    logic         sync_allowed;

    assign char_en = bus.character_clock_enable;

    // Register file next-state: each register takes the data bus on its strobe
    always_comb begin
        r0_d = r0_q;
        r1_d = r1_q;
        r2_d = r2_q;
        r3_d = r3_q;
        if (bus.write_horizontal_total_register) begin
            r0_d = bus.internal_data_bus;
        end
        if (bus.write_horizontal_displayed_register) begin
            r1_d = bus.internal_data_bus;
        end
        if (bus.write_horizontal_sync_position_register) begin
            r2_d = bus.internal_data_bus;
        end
        if (bus.write_horizontal_sync_width_register) begin
            r3_d = bus.internal_data_bus;
        end
    end

    // Column counter, display enable and end-of-line next-state from the old register values
    always_comb begin
        line_end   = (count_q == r0_q);
        count_next = line_end ? 8'd0 : count_q + 8'd1;
        count_d    = count_q;
        display_d  = display_q;
        eol_d      = char_en & line_end;
        if (char_en) begin
            count_d   = count_next;
            display_d = (count_next < r1_q);
        end
    end

    // Width-zero handling decides what the sync down-counter loads
    always_comb begin
`ifdef KF6845_HSYNC_WIDTH_ZERO_IS_16_EN
        sync_load    = (r3_q[3:0] == 4'd0) ? 5'd16 : {1'b0, r3_q[3:0]};
        sync_allowed = 1'b1;
`else
        sync_load    = {1'b0, r3_q[3:0]};
        sync_allowed = (r3_q[3:0] != 4'd0);
`endif
    end

    // HSYNC state machine next-state: start on a position match, count width characters down
    always_comb begin
        state_d    = state_q;
        hsync_d    = hsync_q;
        sync_cnt_d = sync_cnt_q;
        if (char_en) begin
            case (state_q)
                HSYNC_IDLE: begin
                    if ((count_next == r2_q) && sync_allowed) begin
                        state_d    = HSYNC_SYNC;
                        hsync_d    = 1'b1;
                        sync_cnt_d = sync_load;
                    end
                end
                HSYNC_SYNC: begin
                    if (sync_cnt_q == 5'd1) begin
                        state_d    = HSYNC_IDLE;
                        hsync_d    = 1'b0;
                        sync_cnt_d = 5'd0;
                    end else begin
                        sync_cnt_d = sync_cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_d    = HSYNC_IDLE;
                    hsync_d    = 1'b0;
                    sync_cnt_d = 5'd0;
                end
            endcase
        end
    end

    // R0-R3 storage, cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r0_q <= 8'd0;
            r1_q <= 8'd0;
            r2_q <= 8'd0;
            r3_q <= 8'd0;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
        end
    end

    // Column counter, display enable and end-of-line flops
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= 8'd0;
            display_q <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            display_q <= display_d;
            eol_q     <= eol_d;
        end
    end

    // HSYNC state, registered sync output and width down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= HSYNC_IDLE;
            hsync_q    <= 1'b0;
            sync_cnt_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            hsync_q    <= hsync_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    assign horizontal_count    = count_q;
    assign horizontal_display  = display_q;
    assign HSYNC               = hsync_q;
    assign end_of_line         = eol_q;
    assign vertical_sync_width = r3_q[7:4];

endmodule

// File: tb/tb_kf6845_horizontal_control.sv
// Testbench for kf6845_horizontal_control: table-driven line timing vectors
// plus hand-written multi-cycle sequences.
module tb_kf6845_horizontal_control;

    logic       clock;
    logic       reset;
    logic [7:0] horizontal_count;
    logic       horizontal_display;
    logic       HSYNC;
    logic       end_of_line;
    logic [3:0] vertical_sync_width;

    int vectors_applied;
    int miscompares;

    kf6845_horizontal_control_if bus_if ();

    kf6845_horizontal_control dut (
        .clock               (clock),
        .reset               (reset),
        .bus                 (bus_if),
        .horizontal_count    (horizontal_count),
        .horizontal_display  (horizontal_display),
        .HSYNC               (HSYNC),
        .end_of_line         (end_of_line),
        .vertical_sync_width (vertical_sync_width)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       rst;
        logic       ce;
        logic [3:0] wr;
        logic [7:0] data;
        logic [7:0] exp_count;
        logic       exp_disp;
        logic       exp_hsync;
        logic       exp_eol;
        logic [3:0] exp_vsw;
    } vec_t;

    vec_t vecs[64];
    int   num_vecs;

    function automatic void addVec(logic rst, logic ce, logic [3:0] wr, logic [7:0] data,
                                   logic [7:0] ec, logic ed, logic es, logic ee, logic [3:0] ev);
        vecs[num_vecs].rst       = rst;
        vecs[num_vecs].ce        = ce;
        vecs[num_vecs].wr        = wr;
        vecs[num_vecs].data      = data;
        vecs[num_vecs].exp_count = ec;
        vecs[num_vecs].exp_disp  = ed;
        vecs[num_vecs].exp_hsync = es;
        vecs[num_vecs].exp_eol   = ee;
        vecs[num_vecs].exp_vsw   = ev;
        num_vecs++;
    endfunction

    // Drive one clock of inputs (wr bit0=R0 .. bit3=R3) and wait until just after the edge
    task automatic applyStimulus(input logic rst, input logic ce, input logic [3:0] wr, input logic [7:0] data);
        @(negedge clock);
        reset                                          = rst;
        bus_if.character_clock_enable                  = ce;
        bus_if.internal_data_bus                       = data;
        bus_if.write_horizontal_total_register         = wr[0];
        bus_if.write_horizontal_displayed_register     = wr[1];
        bus_if.write_horizontal_sync_position_register = wr[2];
        bus_if.write_horizontal_sync_width_register    = wr[3];
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] ec, input logic ed,
                               input logic es, input logic ee, input logic [3:0] ev);
        vectors_applied++;
        if ({horizontal_count, horizontal_display, HSYNC, end_of_line, vertical_sync_width} !==
            {ec, ed, es, ee, ev}) begin
            miscompares++;
            $display("[TB] FAIL %s: got count=%0d disp=%0b hsync=%0b eol=%0b vsw=%0d, expected count=%0d disp=%0b hsync=%0b eol=%0b vsw=%0d",
                     name, horizontal_count, horizontal_display, HSYNC, end_of_line, vertical_sync_width,
                     ec, ed, es, ee, ev);
        end
    endtask

    task automatic checkCountEol(input string name, input logic [7:0] ec, input logic ee);
        vectors_applied++;
        if ({horizontal_count, end_of_line} !== {ec, ee}) begin
            miscompares++;
            $display("[TB] FAIL %s: got count=%0d eol=%0b, expected count=%0d eol=%0b",
                     name, horizontal_count, end_of_line, ec, ee);
        end
    endtask

    task automatic runEnables(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b0000, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] col;
        logic       exp_d;
        logic       exp_s;
        logic       exp_e;

        vectors_applied = 0;
        miscompares     = 0;
        num_vecs        = 0;
        reset                                          = 1'b1;
        bus_if.character_clock_enable                  = 1'b0;
        bus_if.internal_data_bus                       = 8'h00;
        bus_if.write_horizontal_total_register         = 1'b0;
        bus_if.write_horizontal_displayed_register     = 1'b0;
        bus_if.write_horizontal_sync_position_register = 1'b0;
        bus_if.write_horizontal_sync_width_register    = 1'b0;

        // Line of 10 columns: R0=9, R1=6, R2=7, R3=0x32, enable every clock
        addVec(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 0, 4'b0001, 8'd9,  0, 0, 0, 0, 0);
        addVec(0, 0, 4'b0010, 8'd6,  0, 0, 0, 0, 0);
        addVec(0, 0, 4'b0100, 8'd7,  0, 0, 0, 0, 0);
        addVec(0, 0, 4'b1000, 8'h32, 0, 0, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 1, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 2, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 3, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 4, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 5, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 6, 0, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 7, 0, 1, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 8, 0, 1, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 9, 0, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 0, 1, 0, 1, 3);
        addVec(0, 1, 4'b0000, 8'h00, 1, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 2, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 3, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 4, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 5, 1, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 6, 0, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 7, 0, 1, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 8, 0, 1, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 9, 0, 0, 0, 3);
        addVec(0, 1, 4'b0000, 8'h00, 0, 1, 0, 1, 3);

        // HSYNC spanning the wrap: R0=3, R1=0, R2=2, R3=0x05
        addVec(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 0, 4'b0001, 8'd3,  0, 0, 0, 0, 0);
        addVec(0, 0, 4'b0010, 8'd0,  0, 0, 0, 0, 0);
        addVec(0, 0, 4'b0100, 8'd2,  0, 0, 0, 0, 0);
        addVec(0, 0, 4'b1000, 8'h05, 0, 0, 0, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 1, 0, 0, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 2, 0, 1, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 3, 0, 1, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 0, 0, 1, 1, 0);
        addVec(0, 1, 4'b0000, 8'h00, 1, 0, 1, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 2, 0, 1, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 3, 0, 0, 0, 0);
        addVec(0, 1, 4'b0000, 8'h00, 0, 0, 0, 1, 0);
        addVec(0, 1, 4'b0000, 8'h00, 1, 0, 0, 0, 0);

        for (int i = 0; i < num_vecs; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ce, vecs[i].wr, vecs[i].data);
            checkOutput($sformatf("table[%0d]", i), vecs[i].exp_count, vecs[i].exp_disp,
                        vecs[i].exp_hsync, vecs[i].exp_eol, vecs[i].exp_vsw);
        end

        // Width 0: no sync by default, 16 characters with the width-zero option
        applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'b0001, 8'd20);
        applyStimulus(1'b0, 1'b0, 4'b0100, 8'd2);
        applyStimulus(1'b0, 1'b0, 4'b1000, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b0000, 8'h00);
`ifdef KF6845_HSYNC_WIDTH_ZERO_IS_16_EN
            exp_s = (k >= 2) && (k <= 17);
`else
            exp_s = 1'b0;
`endif
            checkOutput($sformatf("width0[%0d]", k), 8'(k), 1'b0, exp_s, 1'b0, 4'd0);
        end

        // Enable every third clock: R0=2, R1=2, R2=1, R3=0x01
        applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'b0001, 8'd2);
        applyStimulus(1'b0, 1'b0, 4'b0010, 8'd2);
        applyStimulus(1'b0, 1'b0, 4'b0100, 8'd1);
        applyStimulus(1'b0, 1'b0, 4'b1000, 8'h01);
        col   = 8'd0;
        exp_d = 1'b0;
        exp_s = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            applyStimulus(1'b0, (cyc % 3) == 2, 4'b0000, 8'h00);
            exp_e = 1'b0;
            if ((cyc % 3) == 2) begin
                exp_e = (col == 8'd2);
                col   = (col == 8'd2) ? 8'd0 : col + 8'd1;
                exp_d = (col < 8'd2);
                exp_s = (col == 8'd1);
            end
            checkOutput($sformatf("slow_ce[%0d]", cyc), col, exp_d, exp_s, exp_e, 4'd0);
        end

        // R0 rewritten below the count: run to 255, wrap, then wrap at the new total
        applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'b0001, 8'd255);
        runEnables(200);
        checkCountEol("ovr_at_200", 8'd200, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0001, 8'd50);
        checkCountEol("ovr_hold_on_write", 8'd200, 1'b0);
        runEnables(55);
        checkCountEol("ovr_at_255", 8'd255, 1'b0);
        runEnables(1);
        checkCountEol("ovr_wrap_0", 8'd0, 1'b0);
        runEnables(50);
        checkCountEol("ovr_at_50", 8'd50, 1'b0);
        runEnables(1);
        checkCountEol("ovr_new_wrap", 8'd0, 1'b1);
        runEnables(1);
        checkCountEol("ovr_after_wrap", 8'd1, 1'b0);

        // Load and enable on the same edge: the wrap compare uses the old R0
        applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'b0001, 8'd5);
        runEnables(5);
        checkCountEol("same_edge_pre", 8'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0001, 8'd9);
        checkCountEol("same_edge_old_r0", 8'd0, 1'b1);
        runEnables(9);
        checkCountEol("same_edge_new_r0_9", 8'd9, 1'b0);
        runEnables(1);
        checkCountEol("same_edge_new_wrap", 8'd0, 1'b1);

        // Reset while HSYNC is high at column 5, then confirm registers were cleared
        applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'b0001, 8'd9);
        applyStimulus(1'b0, 1'b0, 4'b0010, 8'd6);
        applyStimulus(1'b0, 1'b0, 4'b0100, 8'd4);
        applyStimulus(1'b0, 1'b0, 4'b1000, 8'h54);
        runEnables(5);
        checkOutput("mid_sync", 8'd5, 1'b1, 1'b1, 1'b0, 4'd5);
        applyStimulus(1'b1, 1'b1, 4'b0000, 8'h00);
        checkOutput("reset_mid_sync", 8'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'b0000, 8'h00);
`ifdef KF6845_HSYNC_WIDTH_ZERO_IS_16_EN
        exp_s = 1'b1;
`else
        exp_s = 1'b0;
`endif
        checkOutput("after_reset_r0_zero", 8'd0, 1'b0, exp_s, 1'b1, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'b0000, 8'h00);
        checkOutput("after_reset_eol_again", 8'd0, 1'b0, exp_s, 1'b1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
